// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and widths for the PWM generator/decoder family
// Purpose: decoder FSM state type and the duty scale shared with the fade generators.
// Ports: none (package).
package pwm_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } pwm_dec_state_t;

  // Duty is expressed on a 0..2^R scale, so it needs R+1 bits.
  localparam int PWM_R      = 8;
  localparam int PWM_DUTY_W = PWM_R + 1;

endpackage

// File: rtl/pwm_ratio_div.sv
// rtl/pwm_ratio_div.sv - sequential restoring divider producing floor(num*2^R/den)
// Purpose: computes an R+1 bit ratio, one quotient bit per clock, clamped to 0..2^R.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   start     request; accepted only while not busy
//   num, den  operands (num <= den for a meaningful duty, den > 0)
//   q         registered result, valid with done
//   done      one-cycle pulse when q updates
//   busy      iterations outstanding; a start is ignored while high
module pwm_ratio_div
  import pwm_pkg::*;
#(
  parameter int R     = PWM_R,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num,
  input  logic [CNT_W-1:0] den,
  output logic [R:0]       q,
  output logic             done,
  output logic             busy
);

  localparam int IW = $clog2(R + 1);
  localparam logic [R:0] FULL = {1'b1, {R{1'b0}}};

  logic [CNT_W:0]   rem;
  logic [CNT_W-1:0] den_q;
  logic [R:0]       quo;
  logic [IW-1:0]    iter;

  logic             start_now;
  logic [CNT_W:0]   cur;
  logic [CNT_W:0]   dv;
  logic             qbit;
  logic [CNT_W:0]   diff;
  logic [CNT_W:0]   next_rem;
  logic [R:0]       next_q;

  assign busy      = (iter != '0);
  assign start_now = start & ~busy;

  // The first quotient bit is resolved on the accepting edge straight from
  // the operand inputs; the remaining R bits follow on the next R edges.
  always_comb begin
    cur      = start_now ? {1'b0, num} : rem;
    dv       = start_now ? {1'b0, den} : {1'b0, den_q};
    qbit     = (cur >= dv);
    diff     = qbit ? (cur - dv) : cur;
    next_rem = diff << 1;
    next_q   = start_now ? {{R{1'b0}}, qbit} : {quo[R-1:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      den_q <= '0;
      quo   <= '0;
      iter  <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_now) begin
        rem   <= next_rem;
        den_q <= den;
        quo   <= next_q;
        iter  <= IW'(R);
      end else if (busy) begin
        rem  <= next_rem;
        quo  <= next_q;
        iter <= iter - IW'(1);
        if (iter == IW'(1)) begin
          done <= 1'b1;
          // Only reachable with num > den; a real waveform never exceeds 2^R.
          q    <= (next_q > FULL) ? FULL : next_q;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - measures an incoming PWM waveform and recovers its duty
// Purpose: duty = floor(high*2^R/period) per period, plus stuck-high/low detection.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   pwm_in      asynchronous PWM input
//   duty        last measured duty (0..2^R), held between updates
//   duty_valid  one-cycle pulse when duty updates
//   stuck_high  line high for TIMEOUT clocks without a rising edge (level)
//   stuck_low   line low for TIMEOUT clocks without a rising edge (level)
//   overrun     one-cycle pulse when a measurement is dropped (divider busy)
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int R       = PWM_R,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [R:0] duty,
  output logic       duty_valid,
  output logic       stuck_high,
  output logic       stuck_low,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] TO   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [R:0]       FULL = {1'b1, {R{1'b0}}};

  logic             s1, s, s_d;
  logic             rise;
  pwm_dec_state_t   state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             timeout;

  logic             div_start;
  logic [R:0]       div_q;
  logic             div_done;
  logic             div_busy;

  assign rise = s & ~s_d;

  // Completing a period hands the counts straight to the divider on this edge.
  assign div_start = (state == MEASURE) & rise;

  // A rising edge always beats a timeout. In IDLE the saturated wait counter
  // would otherwise re-fire every cycle, so an existing stuck flag blocks it.
  assign timeout = ~rise &
                   (((state == MEASURE) && (period_cnt == TO)) ||
                    ((state == IDLE) && (wait_cnt == TO) && !stuck_high && !stuck_low));

  pwm_ratio_div #(
    .R     (R),
    .CNT_W (CNT_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (high_cnt),
    .den   (period_cnt),
    .q     (div_q),
    .done  (div_done),
    .busy  (div_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= 1'b0;
      s          <= 1'b0;
      s_d        <= 1'b0;
      state      <= IDLE;
      wait_cnt   <= '0;
      period_cnt <= '0;
      high_cnt   <= '0;
      duty       <= '0;
      duty_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      s1         <= pwm_in;
      s          <= s1;
      s_d        <= s;
      duty_valid <= 1'b0;
      overrun    <= div_start & div_busy;

      if (state == IDLE) begin
        if (rise) begin
          period_cnt <= ONE;
          high_cnt   <= ONE;
          wait_cnt   <= '0;
          stuck_high <= 1'b0;
          stuck_low  <= 1'b0;
          state      <= MEASURE;
        end else if (wait_cnt != TO) begin
          wait_cnt <= wait_cnt + ONE;
        end
      end else begin
        // The rise cycle itself is high, so both counts restart at 1.
        if (rise) begin
          period_cnt <= ONE;
          high_cnt   <= ONE;
        end else begin
          period_cnt <= period_cnt + ONE;
          if (s) high_cnt <= high_cnt + ONE;
        end
      end

      // A timeout needs TIMEOUT clocks since the last accepted period while a
      // division lasts R+1, so the two result sources never compete.
      if (timeout) begin
        state      <= IDLE;
        duty       <= s ? FULL : {(R+1){1'b0}};
        duty_valid <= 1'b1;
        stuck_high <= s;
        stuck_low  <= ~s;
      end else if (div_done) begin
        duty       <= div_q;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule
